scan_seq_nxn: RTL and testbench
===============================

SCAN_SEQ_NXN -- requirements
Module: scan_seq_nxn

Interface
REQ-001 SHALL have parameter MAX_LOG2, default 5, meaning largest supported block is 2^MAX_LOG2 square (legal range 2..5).
REQ-002 SHALL have parameter IDX_W, default 2*MAX_LOG2, meaning width of scan index and raster position.
REQ-003 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port start  input  1  request new scan; sampled only in IDLE.
REQ-006 SHALL have port log2_size  input  3  block size log2 (2=4x4 .. MAX_LOG2), sampled with start.
REQ-007 SHALL have port scan_type  input  2  0=diag up-right, 1=horizontal, 2=vertical, 3=diag; sampled with start.
REQ-008 SHALL have port reverse  input  1  1=emit last-to-first; sampled with start.
REQ-009 SHALL have port abort  input  1  synchronous cancel of the running scan.
REQ-010 SHALL have port out_ready  input  1  downstream accepts current element.
REQ-011 SHALL have port out_valid  output  1  out_* fields hold a valid element.
REQ-012 SHALL have port out_pos  output  IDX_W  raster position y*N+x of element.
REQ-013 SHALL have port out_x / out_y  output  MAX_LOG2 each  column / row of element.
REQ-014 SHALL have port out_idx  output  IDX_W  scan index 0..N*N-1 in emission order.
REQ-015 SHALL have port out_last  output  1  element is final of the scan.
REQ-016 SHALL have ports busy (1, not IDLE), done (1, one-cycle completion pulse), err (1, one-cycle illegal-config pulse), all outputs.

Function
REQ-017 SHALL use states IDLE, RUN, DONE; IDLE->RUN on start with legal log2_size; RUN->DONE on handshake with out_last; DONE->IDLE after one cycle; any state->IDLE on abort.
REQ-018 SHALL decompose N>4 blocks into 4x4 subblocks; subblock order over (N/4)x(N/4) grid and coefficient order within each subblock both follow scan_type.
REQ-019 Diag order SHALL traverse anti-diagonals k=0.. ascending, within each from largest y to smallest y (x ascending).
REQ-020 Horizontal SHALL be row-major; vertical SHALL be column-major (both applied per subblock level).
REQ-021 With reverse=1, sequence SHALL be exact reversal of the forward sequence; out_idx still counts 0..N*N-1.
REQ-022 First element SHALL be valid the cycle after start acceptance (latency 1).
REQ-023 Handshake = out_valid & out_ready; next element SHALL be presented the cycle after each handshake, giving 1 element/cycle with out_ready held high.
REQ-024 While out_valid=1 and out_ready=0, all out_* SHALL hold stable.
REQ-025 done SHALL pulse exactly in the DONE cycle; out_valid SHALL be 0 in DONE and IDLE.
REQ-026 start while busy SHALL be ignored; start in DONE cycle SHALL be ignored.
REQ-027 start with log2_size<2 or >MAX_LOG2 SHALL not leave IDLE and SHALL pulse err next cycle.
REQ-028 abort SHALL take priority over handshake and start in the same cycle; no done pulse follows abort.
REQ-029 Index counter SHALL be IDX_W bits, terminating on index N*N-1 without wrap.

Reset
REQ-030 On rst_n low: state IDLE; out_valid, out_last, busy, done, err = 0; out_pos, out_x, out_y, out_idx = 0; captured config = 0.
REQ-031 Reset mid-scan SHALL abandon the scan immediately with no done pulse after release.

Configuration
REQ-032 Macro SCAN_REVERSE_EN: defined -> reverse honoured per REQ-021; undefined -> reverse port present but ignored (forced 0), reverse logic not synthesised.

Verification
REQ-033 4x4, diag, fwd, out_ready=1 -> out_pos 0,4,1,8,5,2,12,9,6,3,13,10,7,14,11,15; out_last on 16th; done next cycle.
REQ-034 8x8, horizontal, fwd -> out_pos 0,1,2,3,8,9,10,11,...,27 then subblock (1,0) starting 4,5,6,7,12; 64 elements total.
REQ-035 4x4 diag reverse (SCAN_REVERSE_EN defined) -> first out_pos 15,11,14,7; without macro -> 0,4,1.
REQ-036 32x32 vertical with out_ready toggling randomly -> 1024 handshakes, out_* stable under stall, indices 0..1023 exactly once.
REQ-037 start with log2_size=6 -> err pulse, busy stays 0; abort at index 5 -> busy 0 next cycle, no done.

Source files
------------

// File: rtl/scan_seq_nxn.sv
// scan_seq_nxn: coefficient scan-order sequencer for NxN blocks (4x4 subblocks).
// Optional reverse scan support is compiled in with `define SCAN_REVERSE_EN.
// Ports:
//   clk, rst_n         clock / async active-low reset
//   start, log2_size,  new scan request and its config, sampled in IDLE
//   scan_type, reverse
//   abort              synchronous cancel
//   out_ready          downstream accept
//   out_valid, out_pos, out_x, out_y, out_idx, out_last
//                      current element (raster pos, column, row, scan index)
//   busy, done, err    status: not idle, completion pulse, bad-config pulse
module scan_seq_nxn #(
  parameter int MAX_LOG2 = 5,
  parameter int IDX_W    = 2 * MAX_LOG2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [2:0]          log2_size,
  input  logic [1:0]          scan_type,
  input  logic                reverse,
  input  logic                abort,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [IDX_W-1:0]    out_pos,
  output logic [MAX_LOG2-1:0] out_x,
  output logic [MAX_LOG2-1:0] out_y,
  output logic [IDX_W-1:0]    out_idx,
  output logic                out_last,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int CW = MAX_LOG2;

  typedef logic [CW-1:0] crd_t;

  localparam crd_t        C0 = '0;
  localparam crd_t        C1 = crd_t'(1);
  localparam crd_t        C3 = crd_t'(3);
  localparam logic [CW:0] K1 = (CW+1)'(1);
  localparam logic [IDX_W-1:0] I1 = IDX_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [2:0]       log2_q, log2_d;
  logic [1:0]       st_q, st_d;
  crd_t             sx_q, sx_d;
  crd_t             sy_q, sy_d;
  crd_t             cx_q, cx_d;
  crd_t             cy_q, cy_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             err_q, err_d;

  logic             rev_q;
  logic             rev_in;

  logic             lg_ok;
  logic             load;
  logic             fire;
  logic             last;
  logic             adv;
  logic             cend;
  crd_t             mlim;
  crd_t             mlim_new;
  logic [IDX_W-1:0] lastidx;
  logic [2*CW-1:0]  cstep;
  logic [2*CW-1:0]  sstep;

  // Largest subblock coordinate for a block of size 2^lg: (N/4)-1.
  function automatic crd_t lim_of(input logic [2:0] lg);
    crd_t all1;
    int   sh;
    all1 = '1;
    sh   = CW + 2 - int'(lg);
    if (sh < 0) sh = 0;
    return all1 >> sh;
  endfunction

  // One step forward or backward in a (lim+1)x(lim+1) grid.
  // Returns {y, x}. Types 0 and 3 are both the anti-diagonal order.
  function automatic logic [2*CW-1:0] step(
    input logic [1:0] st,
    input logic       bwd,
    input crd_t       x,
    input crd_t       y,
    input crd_t       lim
  );
    logic [CW:0] k;
    crd_t        nx;
    crd_t        ny;
    logic        hor;
    logic        ver;
    nx  = x;
    ny  = y;
    k   = '0;
    hor = (st == 2'd1);
    ver = (st == 2'd2);
    unique case (1'b1)
      hor && !bwd: begin
        if (x == lim) begin
          nx = C0;
          ny = y + C1;
        end else begin
          nx = x + C1;
        end
      end
      hor && bwd: begin
        if (x == C0) begin
          nx = lim;
          ny = y - C1;
        end else begin
          nx = x - C1;
        end
      end
      ver && !bwd: begin
        if (y == lim) begin
          ny = C0;
          nx = x + C1;
        end else begin
          ny = y + C1;
        end
      end
      ver && bwd: begin
        if (y == C0) begin
          ny = lim;
          nx = x - C1;
        end else begin
          ny = y - C1;
        end
      end
      !hor && !ver && !bwd: begin
        // End of a diagonal: jump to the bottom-most cell of the next one.
        if (y == C0 || x == lim) begin
          k  = {1'b0, x} + {1'b0, y} + K1;
          ny = (k > {1'b0, lim}) ? lim : k[CW-1:0];
          nx = k[CW-1:0] - ny;
        end else begin
          nx = x + C1;
          ny = y - C1;
        end
      end
      !hor && !ver && bwd: begin
        // Start of a diagonal: jump to the top-most cell of the previous one.
        if (x == C0 || y == lim) begin
          k  = {1'b0, x} + {1'b0, y} - K1;
          nx = (k > {1'b0, lim}) ? lim : k[CW-1:0];
          ny = k[CW-1:0] - nx;
        end else begin
          nx = x - C1;
          ny = y + C1;
        end
      end
      default: begin
        nx = x;
        ny = y;
      end
    endcase
    return {ny, nx};
  endfunction

`ifdef SCAN_REVERSE_EN
  assign rev_in = reverse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rev_q <= 1'b0;
    end else if (load) begin
      rev_q <= rev_in;
    end
  end
`else
  logic unused_reverse;
  assign unused_reverse = reverse;
  assign rev_in         = 1'b0;
  assign rev_q          = 1'b0;
`endif

  assign lg_ok    = (log2_size >= 3'd2) &&
                    (log2_size <= 3'(MAX_LOG2));
  assign load     = (state_q == IDLE) && start &&
                    !abort && lg_ok;
  assign fire     = (state_q == RUN) && out_ready;
  assign mlim     = lim_of(log2_q);
  assign mlim_new = lim_of(log2_size);

  always_comb begin
    logic [IDX_W-1:0] all1i;
    all1i   = '1;
    lastidx = ~(all1i << (2 * int'(log2_q)));
  end

  assign last  = (idx_q == lastidx);
  assign adv   = fire && !abort && !last;
  assign cend  = rev_q ? (cx_q == C0 && cy_q == C0)
                       : (cx_q == C3 && cy_q == C3);
  assign cstep = step(st_q, rev_q, cx_q, cy_q, C3);
  assign sstep = step(st_q, rev_q, sx_q, sy_q, mlim);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      state_q == IDLE: begin
        if (load) state_d = RUN;
      end
      state_q == RUN: begin
        if (abort)           state_d = IDLE;
        else if (fire && last) state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    busy      = (state_q != IDLE);
    out_valid = (state_q == RUN);
    done      = (state_q == DONE);
    out_last  = (state_q == RUN) && last;
    err       = err_q;
    out_idx   = idx_q;
    out_x     = (sx_q << 2) | cx_q;
    out_y     = (sy_q << 2) | cy_q;
    out_pos   = (IDX_W'(out_y) << log2_q) | IDX_W'(out_x);
  end

  // Datapath next-state: subblock walks only when the coefficient
  // walk has finished its 4x4 tile.
  always_comb begin
    log2_d = log2_q;
    st_d   = st_q;
    sx_d   = sx_q;
    sy_d   = sy_q;
    cx_d   = cx_q;
    cy_d   = cy_q;
    idx_d  = idx_q;
    err_d  = (state_q == IDLE) && start &&
             !abort && !lg_ok;
    if (load) begin
      log2_d = log2_size;
      st_d   = scan_type;
      idx_d  = '0;
      sx_d   = rev_in ? mlim_new : C0;
      sy_d   = rev_in ? mlim_new : C0;
      cx_d   = rev_in ? C3 : C0;
      cy_d   = rev_in ? C3 : C0;
    end else if (adv) begin
      idx_d = idx_q + I1;
      if (cend) begin
        {sy_d, sx_d} = sstep;
        cx_d = rev_q ? C3 : C0;
        cy_d = rev_q ? C3 : C0;
      end else begin
        {cy_d, cx_d} = cstep;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      log2_q <= '0;
      st_q   <= '0;
      sx_q   <= '0;
      sy_q   <= '0;
      cx_q   <= '0;
      cy_q   <= '0;
      idx_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      log2_q <= log2_d;
      st_q   <= st_d;
      sx_q   <= sx_d;
      sy_q   <= sy_d;
      cx_q   <= cx_d;
      cy_q   <= cy_d;
      idx_q  <= idx_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_scan_seq_nxn.sv
// tb_scan_seq_nxn: directed vectors plus reference-order model
// for scan_seq_nxn.
module tb_scan_seq_nxn;

  localparam int ML = 5;
  localparam int IW = 2 * ML;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [2:0]    log2_size;
  logic [1:0]    scan_type;
  logic          reverse;
  logic          abort;
  logic          out_ready;
  logic          out_valid;
  logic [IW-1:0] out_pos;
  logic [ML-1:0] out_x;
  logic [ML-1:0] out_y;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          busy;
  logic          done;
  logic          err;

  scan_seq_nxn #(.MAX_LOG2(ML), .IDX_W(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .log2_size (log2_size),
    .scan_type (scan_type),
    .reverse   (reverse),
    .abort     (abort),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_pos   (out_pos),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef int iq_t[$];

  typedef struct {
    int lg;
    int st;
    int rv;
    int n;
    int pos;
  } vec_t;

  int   checks;
  int   errors;
  int   exp_q[$];
  int   got_q[$];
  bit   seen[1024];
  vec_t tv[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  // Reference order of an m x m grid, encoded y*64+x.
  function automatic iq_t gen(input int m, input int st);
    iq_t q;
    if (st == 1) begin
      for (int y = 0; y < m; y++)
        for (int x = 0; x < m; x++) q.push_back(y * 64 + x);
    end else if (st == 2) begin
      for (int x = 0; x < m; x++)
        for (int y = 0; y < m; y++) q.push_back(y * 64 + x);
    end else begin
      for (int k = 0; k <= 2 * m - 2; k++)
        for (int y = m - 1; y >= 0; y--)
          if (k - y >= 0 && k - y < m) q.push_back(y * 64 + (k - y));
    end
    return q;
  endfunction

  task automatic build_model(input int lg, input int st, input int rv);
    iq_t so;
    iq_t co;
    int  fw[$];
    int  n;
    int  x;
    int  y;
    n  = 1 << lg;
    so = gen(1 << (lg - 2), st);
    co = gen(4, st);
    exp_q.delete();
    foreach (so[i])
      foreach (co[j]) begin
        x = (so[i] % 64) * 4 + (co[j] % 64);
        y = (so[i] / 64) * 4 + (co[j] / 64);
        fw.push_back(y * n + x);
      end
`ifdef SCAN_REVERSE_EN
    if (rv != 0) begin
      for (int i = fw.size() - 1; i >= 0; i--) exp_q.push_back(fw[i]);
    end else begin
      exp_q = fw;
    end
`else
    if (rv > 1) $display("note: reverse ignored");
    exp_q = fw;
`endif
  endtask

  task automatic run_scan(input int lg, input int st, input int rv,
                          input bit rnd, input bit hold);
    int n;
    int total;
    int cnt;
    int budget;
    int nseen;
    bit stalled;
    int sp;
    int sx;
    int sy;
    int si;
    n       = 1 << lg;
    total   = n * n;
    cnt     = 0;
    budget  = 0;
    stalled = 1'b0;
    sp = 0; sx = 0; sy = 0; si = 0;
    build_model(lg, st, rv);
    got_q.delete();
    for (int i = 0; i < 1024; i++) seen[i] = 1'b0;
    start     = 1'b1;
    log2_size = 3'(lg);
    scan_type = 2'(st);
    reverse   = rv[0];
    out_ready = 1'b0;
    @(posedge clk); #1;
    chk("first_valid", int'(out_valid), 1);
    if (hold) begin
      log2_size = 3'd2;
      scan_type = 2'd2;
      reverse   = ~rv[0];
    end else begin
      start = 1'b0;
    end
    while (cnt < total && budget < total * 8 + 100) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_pos", int'(out_pos), sp);
        chk("hold_x", int'(out_x), sx);
        chk("hold_y", int'(out_y), sy);
        chk("hold_idx", int'(out_idx), si);
      end
      if (out_valid) begin
        if (out_ready) begin
          chk("pos", int'(out_pos), exp_q[cnt]);
          chk("idx", int'(out_idx), cnt);
          chk("pos_xy", int'(out_pos), int'(out_y) * n + int'(out_x));
          chk("last", int'(out_last), int'(cnt == total - 1));
          seen[out_pos] = 1'b1;
          got_q.push_back(int'(out_pos));
          cnt++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          sp = int'(out_pos);
          sx = int'(out_x);
          sy = int'(out_y);
          si = int'(out_idx);
        end
      end
      @(posedge clk); #1;
      budget++;
    end
    chk("count", cnt, total);
    out_ready = 1'b0;
    chk("done_pulse", int'(done), 1);
    chk("done_valid", int'(out_valid), 0);
    chk("done_busy", int'(busy), 1);
    @(posedge clk); #1;
    chk("idle_done", int'(done), 0);
    chk("idle_busy", int'(busy), 0);
    start = 1'b0;
    nseen = 0;
    for (int i = 0; i < 1024; i++) nseen += int'(seen[i]);
    chk("unique", nseen, total);
  endtask

  function automatic void add(input int lg, input int st, input int rv,
                              input int n, input int pos);
    vec_t v;
    v.lg = lg; v.st = st; v.rv = rv; v.n = n; v.pos = pos;
    tv.push_back(v);
  endfunction

  initial begin
    int d4[16];
    int h8[21];
    int plg;
    int pst;
    int prv;
    int guard;

    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    log2_size = 3'd0;
    scan_type = 2'd0;
    reverse   = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b0;

    d4 = '{0, 4, 1, 8, 5, 2, 12, 9, 6, 3, 13, 10, 7, 14, 11, 15};
    h8 = '{0, 1, 2, 3, 8, 9, 10, 11, 16, 17, 18, 19,
           24, 25, 26, 27, 4, 5, 6, 7, 12};
    foreach (d4[i]) add(2, 0, 0, i, d4[i]);
    foreach (h8[i]) add(3, 1, 0, i, h8[i]);
`ifdef SCAN_REVERSE_EN
    add(2, 0, 1, 0, 15);
    add(2, 0, 1, 1, 11);
    add(2, 0, 1, 2, 14);
    add(2, 0, 1, 3, 7);
`else
    add(2, 0, 1, 0, 0);
    add(2, 0, 1, 1, 4);
    add(2, 0, 1, 2, 1);
    add(2, 0, 1, 3, 8);
`endif
    add(2, 1, 0, 5, 5);
    add(2, 2, 0, 1, 4);
    add(2, 2, 0, 4, 1);
    add(3, 0, 0, 1, 8);
    add(3, 0, 0, 16, 32);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_last", int'(out_last), 0);
    chk("rst_pos", int'(out_pos), 0);
    chk("rst_x", int'(out_x), 0);
    chk("rst_y", int'(out_y), 0);
    chk("rst_idx", int'(out_idx), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table vectors, one scan per distinct configuration
    plg = -1; pst = -1; prv = -1;
    foreach (tv[i]) begin
      if (tv[i].lg != plg || tv[i].st != pst || tv[i].rv != prv) begin
        run_scan(tv[i].lg, tv[i].st, tv[i].rv, 1'b0, 1'b0);
        plg = tv[i].lg; pst = tv[i].st; prv = tv[i].rv;
      end
      if (tv[i].n < got_q.size())
        chk($sformatf("vec%0d", i), got_q[tv[i].n], tv[i].pos);
      else
        chk($sformatf("vec%0d_short", i), got_q.size(), tv[i].n + 1);
    end

    // Start held high through the scan and its DONE cycle is ignored
    run_scan(3, 1, 0, 1'b0, 1'b1);
    // Randomly stalled scans, including the largest block
    run_scan(5, 2, 0, 1'b1, 1'b0);
    run_scan(3, 0, 1, 1'b1, 1'b0);
    run_scan(4, 2, 1, 1'b1, 1'b1);
    run_scan(4, 3, 0, 1'b0, 1'b0);

    // Illegal sizes
    start = 1'b1; log2_size = 3'd6; scan_type = 2'd0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("err6_pulse", int'(err), 1);
    chk("err6_busy", int'(busy), 0);
    @(posedge clk); #1;
    chk("err6_clear", int'(err), 0);
    chk("err6_idle", int'(busy), 0);
    start = 1'b1; log2_size = 3'd1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("err1_pulse", int'(err), 1);
    chk("err1_busy", int'(busy), 0);

    // Abort beats start in IDLE
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1; log2_size = 3'd2;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", int'(busy), 0);
    chk("abort_start_err", int'(err), 0);

    // Abort at index 5 with a handshake in the same cycle
    start = 1'b1; log2_size = 3'd2; scan_type = 2'd0;
    @(posedge clk); #1;
    start = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (int'(out_idx) != 5 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("abort_reach5", int'(out_idx), 5);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    out_ready = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_valid", int'(out_valid), 0);
    repeat (3) begin
      chk("abort_nodone", int'(done), 0);
      @(posedge clk); #1;
    end

    // Reset in the middle of a scan
    start = 1'b1; log2_size = 3'd3; scan_type = 2'd1;
    @(posedge clk); #1;
    start = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_idx", int'(out_idx), 0);
    chk("mid_rst_pos", int'(out_pos), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("mid_rst_nodone", int'(done), 0);
      chk("mid_rst_idle", int'(busy), 0);
    end
    out_ready = 1'b0;

    // A normal scan after reset still works
    run_scan(2, 0, 0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
